// File: rtl/stereo_frame_sched.sv
// stereo_frame_sched: alternating left/right frame scheduler in front of Fea_Pro, with gap, done hold-off and error flags.
//   Optional timeout on fp_done is compiled in with `define STEREO_SCHED_TIMEOUT_EN.
//   Ports: clk, rst (async, active-low); src_data/src_valid/src_sof/src_ready source stream;
//   img_din/img_din_valid to Fea_Pro; fp_done pair-complete pulse; side, busy, pair_cnt status;
//   err_sync, err_short, err_timeout sticky error flags.
module stereo_frame_sched #(
  parameter int IMG_W        = 120,
  parameter int IMG_H        = 100,
  parameter int GAP_CYCLES   = 100,
  parameter int DONE_TIMEOUT = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  src_data,
  input  logic        src_valid,
  input  logic        src_sof,
  output logic        src_ready,
  output logic [7:0]  img_din,
  output logic        img_din_valid,
  input  logic        fp_done,
  output logic        side,
  output logic        busy,
  output logic [15:0] pair_cnt,
  output logic        err_sync,
  output logic        err_short,
  output logic        err_timeout
);
  localparam int N  = IMG_W * IMG_H;
  localparam int PW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [2:0] {IDLE, STRM_L, GAP_L, STRM_R, WAIT_DONE, GAP_R} state_t;
  state_t state, state_nxt;
  logic [PW-1:0] pix_cnt;
  logic [15:0] gap_cnt;
  logic done_seen, strm, gap, mid_sof, acc, fwd, last, gap_end, done_now, tmo;
  assign strm     = state == STRM_L || state == STRM_R;
  assign gap      = state == GAP_L || state == GAP_R;
  assign mid_sof  = strm && src_valid && src_sof && pix_cnt != '0;
  assign acc      = src_valid && src_ready;
  // at pix_cnt==0 (IDLE, or STRM_R before its first pixel) only an SOF beat starts a frame
  assign fwd      = acc && (pix_cnt != '0 || src_sof);
  assign last     = fwd && strm && pix_cnt == PW'(N - 1);
  assign gap_end  = gap_cnt == 16'(GAP_CYCLES - 1);
  assign done_now = done_seen || fp_done;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state         <= IDLE;
      pix_cnt       <= '0;
      gap_cnt       <= '0;
      done_seen     <= 1'b0;
      pair_cnt      <= '0;
      img_din       <= '0;
      img_din_valid <= 1'b0;
      err_sync      <= 1'b0;
      err_short     <= 1'b0;
    end else begin
      state         <= state_nxt;
      pix_cnt       <= (mid_sof || last) ? '0 : fwd ? pix_cnt + 1'b1 : pix_cnt;
      gap_cnt       <= (gap && !gap_end) ? gap_cnt + 16'd1 : '0;
      done_seen     <= (state == GAP_L && gap_end) ? 1'b0 :
                       (fp_done && (state == STRM_R || state == WAIT_DONE)) ? 1'b1 : done_seen;
      pair_cnt      <= pair_cnt + {15'd0, state == WAIT_DONE && done_now};
      img_din_valid <= fwd;
      if (fwd) img_din <= src_data;
      if (acc && !fwd) err_sync <= 1'b1;
      if (mid_sof) err_short <= 1'b1;
    end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = fwd ? STRM_L : IDLE;
      STRM_L:    state_nxt = mid_sof ? IDLE : last ? GAP_L : STRM_L;
      GAP_L:     state_nxt = gap_end ? STRM_R : GAP_L;
      STRM_R:    state_nxt = mid_sof ? IDLE : last ? WAIT_DONE : STRM_R;
      WAIT_DONE: state_nxt = (done_now || tmo) ? GAP_R : WAIT_DONE;
      GAP_R:     state_nxt = gap_end ? IDLE : GAP_R;
      default:   state_nxt = IDLE;
    endcase
  end
  // src_ready is gated by rst so it reads 0 while reset is held and 1 right after release
  always_comb begin
    src_ready = rst && (state == IDLE || (strm && !(src_sof && pix_cnt != '0)));
    side      = !(state == IDLE || state == STRM_L || state == GAP_L);
    busy      = state != IDLE;
  end
`ifdef STEREO_SCHED_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  assign tmo = tmo_cnt == 32'(DONE_TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      tmo_cnt <= state == WAIT_DONE ? tmo_cnt + 32'd1 : '0;
      if (state == WAIT_DONE && !done_now && tmo) err_timeout <= 1'b1;
    end
`else
  assign tmo         = 1'b0;
  assign err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_stereo_frame_sched.sv
// tb_stereo_frame_sched: directed self-checking bench for stereo_frame_sched (IMG 4x2, gap 3, timeout 20).
module tb_stereo_frame_sched;
  logic clk = 1'b0, rst = 1'b0;
  logic [7:0] src_data = '0;
  logic src_valid = 1'b0, src_sof = 1'b0, fp_done = 1'b0;
  logic src_ready, img_din_valid, side, busy, err_sync, err_short, err_timeout;
  logic [7:0] img_din;
  logic [15:0] pair_cnt;
  logic rdy_seen = 1'b0;
  int total = 0, passes = 0, fails = 0;
  stereo_frame_sched #(.IMG_W(4), .IMG_H(2), .GAP_CYCLES(3), .DONE_TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .src_data(src_data), .src_valid(src_valid), .src_sof(src_sof),
    .src_ready(src_ready), .img_din(img_din), .img_din_valid(img_din_valid), .fp_done(fp_done),
    .side(side), .busy(busy), .pair_cnt(pair_cnt), .err_sync(err_sync), .err_short(err_short),
    .err_timeout(err_timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] d, input logic v, input logic s);
    src_data = d; src_valid = v; src_sof = s;
    #1 rdy_seen = src_ready;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) send(8'h00, 1'b0, 1'b0);
  endtask
  task automatic frame(input logic [7:0] base, input string tag, input int done_at);
    for (int i = 0; i < 8; i++) begin
      fp_done = (i == done_at);
      send(base + 8'(i), 1'b1, i == 0);
      chk({tag, "_rdy"}, rdy_seen, 1);
      chk({tag, "_v"}, img_din_valid, 1);
      chk({tag, "_d"}, img_din, base + 8'(i));
    end
    fp_done = 1'b0;
  endtask
  task automatic done_pulse;
    fp_done = 1'b1;
    idle(1);
    fp_done = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", src_ready, 0);
    chk("rst_din", img_din, 0);
    chk("rst_v", img_din_valid, 0);
    chk("rst_side", side, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pairs", pair_cnt, 0);
    chk("rst_errs", {err_sync, err_short, err_timeout}, 0);
    rst = 1'b1;
    #1 chk("rel_rdy", src_ready, 1);
    // nominal pair
    frame(8'h01, "l0", -1);
    chk("l0_end_busy", busy, 1);
    chk("l0_end_side", side, 0);
    for (int j = 0; j < 3; j++) begin
      send(8'h09, 1'b1, 1'b1);
      chk("gap_rdy", rdy_seen, 0);
      chk("gap_v", img_din_valid, 0);
    end
    frame(8'h09, "r0", -1);
    chk("wd_side", side, 1);
    chk("wd_busy", busy, 1);
    idle(4);
    chk("wd_rdy", rdy_seen, 0);
    chk("wd_pairs", pair_cnt, 0);
    done_pulse();
    chk("n_pairs", pair_cnt, 1);
    chk("gr_side", side, 1);
    idle(2);
    chk("gr_busy", busy, 1);
    idle(1);
    chk("n_idle_busy", busy, 0);
    chk("n_idle_side", side, 0);
    chk("n_idle_rdy", src_ready, 1);
    chk("n_errs", {err_sync, err_short, err_timeout}, 0);
    // bubbles, fp_done arriving during the right frame
    for (int i = 0; i < 3; i++) begin
      send(8'h11 + 8'(i), 1'b1, i == 0);
      chk("b_d", img_din, 8'h11 + 8'(i));
    end
    idle(1);
    chk("b_bub1", img_din_valid, 0);
    idle(1);
    chk("b_bub2", img_din_valid, 0);
    for (int i = 3; i < 8; i++) begin
      send(8'h11 + 8'(i), 1'b1, 1'b0);
      chk("b_v", img_din_valid, 1);
      chk("b_d", img_din, 8'h11 + 8'(i));
    end
    for (int j = 0; j < 3; j++) begin
      send(8'h19, 1'b1, 1'b1);
      chk("b_gap_rdy", rdy_seen, 0);
    end
    frame(8'h19, "r1", 0);
    idle(1);
    chk("b_pairs", pair_cnt, 2);
    idle(3);
    chk("b_busy", busy, 0);
    chk("b_errs", {err_sync, err_short, err_timeout}, 0);
    // sync error: non-SOF beats in IDLE are dropped
    for (int i = 0; i < 3; i++) begin
      send(8'hA0 + 8'(i), 1'b1, 1'b0);
      chk("s_rdy", rdy_seen, 1);
      chk("s_v", img_din_valid, 0);
    end
    chk("s_err", err_sync, 1);
    chk("s_busy", busy, 0);
    frame(8'h21, "l2", -1);
    idle(3);
    frame(8'h29, "r2", -1);
    done_pulse();
    chk("s_pairs", pair_cnt, 3);
    idle(3);
    chk("s_idle", busy, 0);
    // truncation: SOF at left pixel 5
    for (int i = 0; i < 5; i++) begin
      send(8'h41 + 8'(i), 1'b1, i == 0);
      chk("t_d", img_din, 8'h41 + 8'(i));
    end
    send(8'h50, 1'b1, 1'b1);
    chk("t_rdy", rdy_seen, 0);
    chk("t_err", err_short, 1);
    chk("t_busy", busy, 0);
    chk("t_v", img_din_valid, 0);
    send(8'h50, 1'b1, 1'b1);
    chk("t_re_rdy", rdy_seen, 1);
    chk("t_re_d", img_din, 8'h50);
    chk("t_re_v", img_din_valid, 1);
    chk("t_re_busy", busy, 1);
    chk("t_re_side", side, 0);
    chk("t_pairs", pair_cnt, 3);
    for (int i = 1; i < 8; i++) begin
      send(8'h50 + 8'(i), 1'b1, 1'b0);
      chk("t_d2", img_din, 8'h50 + 8'(i));
    end
    idle(3);
    frame(8'h58, "r3", -1);
    // no fp_done: timeout behaviour
    idle(19);
    chk("to_pre", err_timeout, 0);
    chk("to_pre_busy", busy, 1);
    idle(1);
`ifdef STEREO_SCHED_TIMEOUT_EN
    chk("to_err", err_timeout, 1);
    chk("to_pairs", pair_cnt, 3);
    chk("to_side", side, 1);
    idle(3);
    chk("to_idle", busy, 0);
`else
    chk("to_err", err_timeout, 0);
    chk("to_busy", busy, 1);
    idle(3);
    chk("to_busy2", busy, 1);
    done_pulse();
    chk("to_pairs", pair_cnt, 4);
    idle(3);
    chk("to_idle", busy, 0);
`endif
    // reset in the middle of the right frame
    frame(8'h61, "l4", -1);
    idle(3);
    send(8'h69, 1'b1, 1'b1);
    send(8'h6A, 1'b1, 1'b0);
    src_data = 8'h6B;
    rst = 1'b0;
    #1;
    chk("mr_rdy", src_ready, 0);
    chk("mr_din", img_din, 0);
    chk("mr_v", img_din_valid, 0);
    chk("mr_side", side, 0);
    chk("mr_busy", busy, 0);
    chk("mr_pairs", pair_cnt, 0);
    chk("mr_errs", {err_sync, err_short, err_timeout}, 0);
    #1 rst = 1'b1;
    #1 chk("mr_rel_rdy", src_ready, 1);
    send(8'h71, 1'b1, 1'b1);
    chk("mr_new_d", img_din, 8'h71);
    chk("mr_new_v", img_din_valid, 1);
    chk("mr_new_side", side, 0);
    chk("mr_new_busy", busy, 1);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
